// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared constants, state encoding and digit helper for the
//            bulls-and-cows scoring engine.
// Revision : 1.0  initial release
// ============================================================================
package game_pkg;

    localparam int N_DIGITS = 4;
    localparam int BCD_MAX  = 9;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_COLLECT = 3'd1;
    localparam state_t S_CHECK   = 3'd2;
    localparam state_t S_SCORE   = 3'd3;
    localparam state_t S_RESULT  = 3'd4;

    // Digit 0 is the leftmost nibble [15:12], digit 3 is [3:0].
    function automatic logic [3:0] get_digit(input logic [15:0] word,
                                             input logic [1:0]  idx);
        logic [1:0] pos;
        pos = 2'd3 - idx;
        return word[{pos, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_set_check.sv
`default_nettype none
// ============================================================================
// Module   : digit_set_check
// Purpose  : Combinational legality check of a four-digit BCD word.
// Ports    : i_word         16-bit word, four BCD digits
//            o_in_range     every digit is 0..9
//            o_all_distinct no two digits are equal
// Revision : 1.0  initial release
// ============================================================================
module digit_set_check
    import game_pkg::*;
(
    input  logic [15:0] i_word,
    output logic        o_in_range,
    output logic        o_all_distinct
);

    always_comb begin
        o_in_range     = 1'b1;
        o_all_distinct = 1'b1;
        for (int a = 0; a < N_DIGITS; a++) begin
            if (get_digit(i_word, 2'(a)) > 4'(BCD_MAX)) o_in_range = 1'b0;
            for (int b = a + 1; b < N_DIGITS; b++) begin
                if (get_digit(i_word, 2'(a)) == get_digit(i_word, 2'(b)))
                    o_all_distinct = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/guess_scorer.sv
`default_nettype none
// ============================================================================
// Module   : guess_scorer
// Purpose  : Bulls-and-cows scoring engine. Holds the secret, collects a
//            four-digit guess, rejects illegal guesses, scores ?A?B serially
//            over 16 cycles and tracks the attempt count.
// Ports    : clk, rst                 clock, synchronous active-high reset
//            secret_load, secret_in   start a new game with a BCD secret
//            digit_valid, digit_in    guess digit offer from upstream
//            digit_ready              engine accepts a digit this cycle
//            guess_disp, digit_count  guess digits held (newest in [3:0])
//            score_a, score_b         last score
//            score_valid              pulse: new score
//            reach_result             level: a score is showing
//            ans_correct              level: last score was 4A0B
//            in_error                 pulse: digit, guess or secret rejected
//            attempts, game_over      attempt counter and end-of-game level
// Revision : 1.0  initial release
// ============================================================================
module guess_scorer
    import game_pkg::*;
#(
    parameter int MAX_ATTEMPTS = 10,
    parameter int CNT_W        = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             secret_load,
    input  logic [15:0]      secret_in,
    input  logic             digit_valid,
    input  logic [3:0]       digit_in,
    output logic             digit_ready,
    output logic [15:0]      guess_disp,
    output logic [2:0]       digit_count,
    output logic [CNT_W-1:0] score_a,
    output logic [CNT_W-1:0] score_b,
    output logic             score_valid,
    output logic             reach_result,
    output logic             ans_correct,
    output logic             in_error,
    output logic [CNT_W-1:0] attempts,
    output logic             game_over
);

    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_ATTEMPTS);

    state_t      r_state;
    logic [15:0] r_secret;
    logic [3:0]  r_k;
    logic [2:0]  r_acc_a;
    logic [2:0]  r_acc_b;

    logic        w_sec_range, w_sec_distinct, w_secret_ok;
    logic        w_guess_range, w_guess_distinct, w_guess_ok;
    logic        w_digit_bad, w_digit_ok;
    logic [3:0]  w_g_digit, w_s_digit;
    logic        w_hit, w_hit_a, w_hit_b;
    logic [2:0]  w_acc_a_next, w_acc_b_next;

    digit_set_check u_secret_chk (
        .i_word         (secret_in),
        .o_in_range     (w_sec_range),
        .o_all_distinct (w_sec_distinct)
    );

    digit_set_check u_guess_chk (
        .i_word         (guess_disp),
        .o_in_range     (w_guess_range),
        .o_all_distinct (w_guess_distinct)
    );

    assign w_secret_ok = w_sec_range && w_sec_distinct;
    assign w_guess_ok  = w_guess_range && w_guess_distinct;

    assign digit_ready = (r_state == S_COLLECT) ||
                         ((r_state == S_RESULT) && !game_over);
    assign w_digit_bad = digit_ready && digit_valid && (digit_in > 4'(BCD_MAX));
    assign w_digit_ok  = digit_ready && digit_valid && !(digit_in > 4'(BCD_MAX));

    // Serial compare: k walks guess digit i = k[3:2] against secret digit j = k[1:0].
    assign w_g_digit    = get_digit(guess_disp, r_k[3:2]);
    assign w_s_digit    = get_digit(r_secret, r_k[1:0]);
    assign w_hit        = (w_g_digit == w_s_digit);
    assign w_hit_a      = w_hit && (r_k[3:2] == r_k[1:0]);
    assign w_hit_b      = w_hit && (r_k[3:2] != r_k[1:0]);
    assign w_acc_a_next = r_acc_a + {2'b00, w_hit_a};
    assign w_acc_b_next = r_acc_b + {2'b00, w_hit_b};

    // The error pulse flags the offending cycle itself: the rejected secret
    // or digit is on the inputs, or the duplicate guess is in CHECK.
    always_comb begin
        in_error = 1'b0;
        if (!rst) begin
            if (secret_load)
                in_error = !w_secret_ok;
            else if (w_digit_bad)
                in_error = 1'b1;
            else if ((r_state == S_CHECK) && !w_guess_ok)
                in_error = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_secret     <= '0;
            r_k          <= '0;
            r_acc_a      <= '0;
            r_acc_b      <= '0;
            guess_disp   <= '0;
            digit_count  <= '0;
            score_a      <= '0;
            score_b      <= '0;
            score_valid  <= 1'b0;
            reach_result <= 1'b0;
            ans_correct  <= 1'b0;
            attempts     <= '0;
            game_over    <= 1'b0;
        end else begin
            score_valid <= 1'b0;
            if (secret_load) begin
                if (w_secret_ok) begin
                    r_secret     <= secret_in;
                    r_k          <= '0;
                    r_acc_a      <= '0;
                    r_acc_b      <= '0;
                    guess_disp   <= '0;
                    digit_count  <= '0;
                    score_a      <= '0;
                    score_b      <= '0;
                    reach_result <= 1'b0;
                    ans_correct  <= 1'b0;
                    attempts     <= '0;
                    game_over    <= 1'b0;
                    r_state      <= S_COLLECT;
                end else begin
                    r_state <= S_IDLE;
                end
            end else begin
                case (r_state)
                    S_COLLECT: begin
                        if (w_digit_ok) begin
                            guess_disp  <= {guess_disp[11:0], digit_in};
                            digit_count <= digit_count + 3'd1;
                            if (digit_count == 3'(N_DIGITS - 1)) r_state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (!w_guess_ok) begin
                            guess_disp  <= '0;
                            digit_count <= '0;
                            r_state     <= S_COLLECT;
                        end else begin
                            if (attempts != c_MAX) attempts <= attempts + 1'b1;
                            r_k     <= '0;
                            r_acc_a <= '0;
                            r_acc_b <= '0;
                            r_state <= S_SCORE;
                        end
                    end
                    S_SCORE: begin
                        r_acc_a <= w_acc_a_next;
                        r_acc_b <= w_acc_b_next;
                        r_k     <= r_k + 4'd1;
                        // Last compare folds straight into the result registers
                        // so the score shows on the RESULT entry cycle.
                        if (r_k == 4'd15) begin
                            score_a      <= CNT_W'(w_acc_a_next);
                            score_b      <= CNT_W'(w_acc_b_next);
                            score_valid  <= 1'b1;
                            reach_result <= 1'b1;
                            ans_correct  <= (w_acc_a_next == 3'(N_DIGITS));
                            game_over    <= (w_acc_a_next == 3'(N_DIGITS)) ||
                                            (attempts == c_MAX);
                            r_state      <= S_RESULT;
                        end
                    end
                    S_RESULT: begin
                        // A new digit starts the next guess from scratch.
                        if (w_digit_ok) begin
                            guess_disp   <= {12'h000, digit_in};
                            digit_count  <= 3'd1;
                            reach_result <= 1'b0;
                            r_state      <= S_COLLECT;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_guess_scorer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_guess_scorer
// Purpose  : Self-checking bench for guess_scorer with a behavioural
//            bulls-and-cows reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_guess_scorer;

    localparam int MAXA = 2;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          secret_load = 1'b0;
    logic [15:0]   secret_in = '0;
    logic          digit_valid = 1'b0;
    logic [3:0]    digit_in = '0;
    logic          digit_ready;
    logic [15:0]   guess_disp;
    logic [2:0]    digit_count;
    logic [CW-1:0] score_a, score_b, attempts;
    logic          score_valid, reach_result, ans_correct, in_error, game_over;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_secret;
    int          m_attempts;
    bit          m_over;

    always #5 clk = ~clk;

    guess_scorer #(.MAX_ATTEMPTS(MAXA), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .secret_load  (secret_load),
        .secret_in    (secret_in),
        .digit_valid  (digit_valid),
        .digit_in     (digit_in),
        .digit_ready  (digit_ready),
        .guess_disp   (guess_disp),
        .digit_count  (digit_count),
        .score_a      (score_a),
        .score_b      (score_b),
        .score_valid  (score_valid),
        .reach_result (reach_result),
        .ans_correct  (ans_correct),
        .in_error     (in_error),
        .attempts     (attempts),
        .game_over    (game_over)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Four distinct random decimal digits, packed leftmost-first.
    function automatic logic [15:0] rand_word();
        int pool[10];
        int j, t;
        for (int i = 0; i < 10; i++) pool[i] = i;
        for (int i = 9; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = pool[i]; pool[i] = pool[j]; pool[j] = t;
        end
        return {4'(pool[0]), 4'(pool[1]), 4'(pool[2]), 4'(pool[3])};
    endfunction

    // Bulls = same digit same place; cows = shared digits minus bulls.
    task automatic ref_score(input logic [15:0] s, input logic [15:0] g,
                             output int a, output int b);
        int sd[4], gd[4];
        int common;
        for (int i = 0; i < 4; i++) begin
            sd[i] = int'(s[15-4*i -: 4]);
            gd[i] = int'(g[15-4*i -: 4]);
        end
        a = 0; common = 0;
        for (int i = 0; i < 4; i++) begin
            if (gd[i] == sd[i]) a++;
            for (int k = 0; k < 4; k++) if (gd[i] == sd[k]) common++;
        end
        b = common - a;
    endtask

    task automatic load_secret(input logic [15:0] s);
        secret_in   = s;
        secret_load = 1'b1;
        tick();
        secret_load = 1'b0;
        m_secret    = s;
        m_attempts  = 0;
        m_over      = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] d);
        digit_in    = d;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
    endtask

    // Enter a full legal guess and check latency, score and game status.
    task automatic run_guess(input logic [15:0] g);
        int ea, eb, n;
        bit seen;
        send_digit(g[15:12]);
        total++;
        if (digit_count !== 3'd1 || reach_result !== 1'b0) begin
            bad++;
            $display("FAIL first_digit: count=%0d reach=%0b want count=1 reach=0", digit_count, reach_result);
        end
        send_digit(g[11:8]);
        send_digit(g[7:4]);
        send_digit(g[3:0]);
        total++;
        if (guess_disp !== g) begin
            bad++;
            $display("FAIL guess_disp: got %h want %h", guess_disp, g);
        end
        ref_score(m_secret, g, ea, eb);
        if (m_attempts < MAXA) m_attempts++;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (score_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || n != 17) begin
            bad++;
            $display("FAIL latency: seen=%0b cycles=%0d want 17", seen, n);
        end
        m_over = (ea == 4) || (m_attempts == MAXA);
        total++;
        if ({score_a, score_b} !== {CW'(ea), CW'(eb)}) begin
            bad++;
            $display("FAIL score %h vs %h: got %0dA%0dB want %0dA%0dB", m_secret, g, score_a, score_b, ea, eb);
        end
        total++;
        if (attempts !== CW'(m_attempts) || game_over !== m_over || ans_correct !== (ea == 4) ||
            reach_result !== 1'b1 || digit_ready !== !m_over) begin
            bad++;
            $display("FAIL status: att=%0d over=%0b ok=%0b reach=%0b rdy=%0b want att=%0d over=%0b ok=%0b reach=1 rdy=%0b",
                     attempts, game_over, ans_correct, reach_result, digit_ready, m_attempts, m_over, ea == 4, !m_over);
        end
        tick();
        total++;
        if (score_valid !== 1'b0) begin
            bad++;
            $display("FAIL valid_pulse: score_valid=%0b want 0", score_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({guess_disp, digit_count, score_a, score_b, score_valid, reach_result, ans_correct,
             in_error, attempts, game_over, digit_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: nonzero output guess=%h cnt=%0d rdy=%0b", guess_disp, digit_count, digit_ready);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_exact();
        load_secret(16'h1234);
        run_guess(16'h1234);
        send_digit(4'd5);
        total++;
        if (digit_count !== 3'd4 || reach_result !== 1'b1) begin
            bad++;
            $display("FAIL exact_hold: count=%0d reach=%0b want 4,1", digit_count, reach_result);
        end
    endtask

    task automatic test_patterns_max();
        load_secret(16'h1234);
        run_guess(16'h4321);
        load_secret(16'h1234);
        run_guess(16'h1243);
        run_guess(16'h5678);
        send_digit(4'd7);
        total++;
        if (digit_count !== 3'd4 || digit_ready !== 1'b0 || game_over !== 1'b1) begin
            bad++;
            $display("FAIL max_hold: count=%0d rdy=%0b over=%0b want 4,0,1", digit_count, digit_ready, game_over);
        end
        load_secret(16'h9876);
        total++;
        if (attempts !== '0 || game_over !== 1'b0 || reach_result !== 1'b0 || digit_ready !== 1'b1) begin
            bad++;
            $display("FAIL reload_clear: att=%0d over=%0b reach=%0b rdy=%0b want 0,0,0,1", attempts, game_over, reach_result, digit_ready);
        end
    endtask

    task automatic test_dup();
        load_secret(16'h1234);
        send_digit(4'd1);
        send_digit(4'd1);
        send_digit(4'd2);
        send_digit(4'd3);
        total++;
        if (in_error !== 1'b1 || digit_ready !== 1'b0) begin
            bad++;
            $display("FAIL dup_check: err=%0b rdy=%0b want 1,0", in_error, digit_ready);
        end
        tick();
        total++;
        if (digit_count !== 3'd0 || guess_disp !== 16'h0 || attempts !== '0 || digit_ready !== 1'b1 || in_error !== 1'b0) begin
            bad++;
            $display("FAIL dup_after: cnt=%0d guess=%h att=%0d rdy=%0b err=%0b want 0,0000,0,1,0",
                     digit_count, guess_disp, attempts, digit_ready, in_error);
        end
    endtask

    task automatic test_bad_digit_secret();
        send_digit(4'd5);
        digit_in    = 4'd12;
        digit_valid = 1'b1;
        #1;
        total++;
        if (in_error !== 1'b1) begin
            bad++;
            $display("FAIL bad_digit_err: err=%0b want 1", in_error);
        end
        tick();
        digit_valid = 1'b0;
        total++;
        if (digit_count !== 3'd1 || guess_disp !== 16'h0005) begin
            bad++;
            $display("FAIL bad_digit_drop: cnt=%0d guess=%h want 1,0005", digit_count, guess_disp);
        end
        secret_in   = 16'h1134;
        secret_load = 1'b1;
        #1;
        total++;
        if (in_error !== 1'b1) begin
            bad++;
            $display("FAIL bad_secret_err: err=%0b want 1", in_error);
        end
        tick();
        secret_load = 1'b0;
        send_digit(4'd6);
        total++;
        if (digit_ready !== 1'b0 || digit_count !== 3'd1) begin
            bad++;
            $display("FAIL bad_secret_idle: rdy=%0b cnt=%0d want 0,1", digit_ready, digit_count);
        end
    endtask

    task automatic test_abort_and_rst();
        bit seen;
        load_secret(16'h1234);
        send_digit(4'd5); send_digit(4'd6); send_digit(4'd7); send_digit(4'd8);
        repeat (6) tick();
        load_secret(16'h4321);
        total++;
        if (attempts !== '0 || digit_count !== 3'd0 || guess_disp !== 16'h0 || reach_result !== 1'b0 || digit_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_clear: att=%0d cnt=%0d guess=%h reach=%0b rdy=%0b want 0,0,0000,0,1",
                     attempts, digit_count, guess_disp, reach_result, digit_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (score_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_novalid: score_valid seen=%0b want 0", seen);
        end
        send_digit(4'd2);
        send_digit(4'd9);
        rst = 1'b1;
        tick();
        total++;
        if ({guess_disp, digit_count, score_a, score_b, score_valid, reach_result, ans_correct,
             in_error, attempts, game_over, digit_ready} !== '0) begin
            bad++;
            $display("FAIL rst_mid: nonzero output guess=%h cnt=%0d rdy=%0b", guess_disp, digit_count, digit_ready);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [15:0] g;
        load_secret(rand_word());
        for (int it = 0; it < 24; it++) begin
            if (m_over) load_secret(rand_word());
            g = ($urandom_range(3, 0) == 0) ? m_secret : rand_word();
            run_guess(g);
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_patterns_max();
        test_dup();
        test_bad_digit_secret();
        test_abort_and_rst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
